// File: rtl/sincos_if.sv
// Handshake bundle between two angle requesters, the shared sin/cos unit and the
// response consumer; the scheduler connects through the master modport.
interface sincos_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_angle;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_angle;
    logic             req1_ready;
    logic             calc_start;
    logic [WIDTH-1:0] calc_angle;
    logic             calc_done;
    logic [WIDTH-1:0] calc_sine;
    logic [WIDTH-1:0] calc_cosine;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sine;
    logic [WIDTH-1:0] rsp_cosine;
    logic             rsp_timeout;
    logic             busy;

    modport master (
        input  req0_valid, req0_angle, req1_valid, req1_angle,
        output req0_ready, req1_ready,
        output calc_start, calc_angle,
        input  calc_done, calc_sine, calc_cosine,
        output rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_timeout, busy,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_angle, req1_valid, req1_angle,
        input  req0_ready, req1_ready,
        input  calc_start, calc_angle,
        output calc_done, calc_sine, calc_cosine,
        input  rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_timeout, busy,
        output rsp_ready
    );
endinterface

// File: rtl/sincos_scheduler.sv
// Round-robin scheduler sharing one sin/cos unit between two requesters, one
// transaction at a time, with a per-transaction result timeout.
module sincos_scheduler #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic     clock,
    input  logic     reset_n,
    sincos_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] angle_q;
    logic             id_q;
    logic             rr_q;
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] sine_q, cosine_q;
    logic             tmo_q;
    logic             rid_q;

    logic gnt_vld, gnt_id, done_hit, tmo_hit, rsp_hs;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        gnt_vld  = 1'b0;
        gnt_id   = 1'b0;
        done_hit = 1'b0;
        tmo_hit  = 1'b0;
        rsp_hs   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    gnt_vld = 1'b1;
                    // On a tie the requester not served last wins.
                    gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~rr_q : bus.req1_valid;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.calc_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            angle_q  <= '0;
            id_q     <= 1'b0;
            rr_q     <= 1'b1;
            cnt_q    <= '0;
            sine_q   <= '0;
            cosine_q <= '0;
            tmo_q    <= 1'b0;
            rid_q    <= 1'b0;
        end else begin
            if (gnt_vld) begin
                angle_q <= gnt_id ? bus.req1_angle : bus.req0_angle;
                id_q    <= gnt_id;
            end
            if (state_q == START)
                cnt_q <= '0;
            else if (state_q == WAIT && !done_hit && !tmo_hit)
                cnt_q <= cnt_q + 16'd1;
            // Response fields change only on entry to RESP and hold otherwise.
            if (done_hit) begin
                sine_q   <= bus.calc_sine;
                cosine_q <= bus.calc_cosine;
                tmo_q    <= 1'b0;
                rid_q    <= id_q;
            end else if (tmo_hit) begin
                sine_q   <= '0;
                cosine_q <= '0;
                tmo_q    <= 1'b1;
                rid_q    <= id_q;
            end
            if (rsp_hs) rr_q <= rid_q;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign bus.req0_ready  = reset_n && gnt_vld && !gnt_id;
    assign bus.req1_ready  = reset_n && gnt_vld && gnt_id;
    assign bus.calc_start  = (state_q == START);
    assign bus.calc_angle  = (state_q == START || state_q == WAIT) ? angle_q : '0;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rid_q;
    assign bus.rsp_sine    = sine_q;
    assign bus.rsp_cosine  = cosine_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
